uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter for 9N1 UART framing: 1 start bit, 9 data bits sent LSB first, no parity, 1 stop bit.
- Accepts a 9-bit word on a level `send` request while idle and shifts it out on a single line at a fixed clocks-per-bit rate.
- Sits between the controller logic and the board TX pin.
- `ready` signals the idle state and acts as the accept handshake.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are 2 or more.
- DATA_W, 9, data bits per frame. Fixed at 9 for 9N1; kept as a parameter for readability only.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- send   input  1  level request to transmit `data`.
- data   input  9  word to transmit; sampled only when a frame is accepted.
- tx     output 1  serial line; idles high.
- ready  output 1  high when idle and able to accept a frame.

Behaviour:
- Reset values (applied on the clock edge where reset=1):
  - tx=1, ready=1.
  - State IDLE, bit counter 0, clock counter 0, shift register 0.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx=1, ready=1.
  - If send=1 at a clock edge: latch data into the shift register, clear the counters, enter START. ready=0 and tx=0 from the next cycle.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift[0].
  - Every CLKS_PER_BIT cycles, shift right one bit and increment the bit counter.
  - After the 9th bit (data[8]) has been held for its full period, enter STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with ready=1.
- Frame length: 11*CLKS_PER_BIT cycles, from the first tx=0 cycle to the last stop cycle.
- Handshake:
  - A frame is accepted on any edge where ready=1 and send=1.
  - `send` is level-sensitive. If it stays high, a new frame is accepted on the single IDLE cycle after each STOP, so back-to-back frames are separated by exactly 1 idle cycle (tx=1, ready=1).
  - send=0 while a frame is in progress has no effect; the frame completes.
- Changes to `data` during a frame are ignored; only the value latched at acceptance is sent.
- Reset mid-frame: on the next edge tx=1, ready=1, state IDLE. The partial frame is abandoned with no stop bit.
- Reset and send high on the same edge: reset wins and no frame is accepted.
- Clock counter: runs 0..CLKS_PER_BIT-1 and wraps at the end of each bit period. Width is clog2(CLKS_PER_BIT). Bit counter width is 4.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit is inserted between data[8] and the stop bit, using state PARITY for CLKS_PER_BIT cycles.
  - tx = XOR of the 9 latched data bits.
  - Frame length is 12*CLKS_PER_BIT.
- Undefined: pure 9N1 as above, with no PARITY state.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam UART_DATA_W = 9.
  - localparam UART_STOP_BITS = 1.
- One sub-module, uart_baud_cnt:
  - Counts to CLKS_PER_BIT-1.
  - Outputs a one-cycle `bit_done` pulse.
  - Has a synchronous clear from the FSM.

Test Plan:
- Reset, then idle 4 cycles -> tx=1 and ready=1 throughout.
- Single frame: send=1 for one cycle with data=9'b0_1101_0101, CLKS_PER_BIT=16.
  - tx = 0 for 16 cycles.
  - Then bits 1,0,1,0,1,0,1,1,0, each 16 cycles.
  - Then 1 for 16 cycles.
  - ready=0 for exactly 176 cycles.
- send held high for 5000 cycles with the same data -> repeated identical 176-cycle frames, each separated by exactly 1 idle cycle. Then send=0 for 5000 cycles -> the current frame finishes and tx stays 1 afterwards.
- Change data to 9'h1FF in the middle of a frame -> the in-flight frame still carries the original bits; the next accepted frame carries 9'h1FF.
- Assert reset during DATA bit 4 -> the next cycle has tx=1, ready=1; a fresh send starts a full new frame with a complete start bit.
- With UART_TX_PARITY_EN and data=9'b0_1101_0101 (five ones) -> parity bit 1 after data[8]; frame of 192 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the 9N1 UART transmitter.
//   - tx_state_t     : transmitter FSM state encoding
//   - UART_DATA_W    : data bits per frame (9)
//   - UART_STOP_BITS : stop bits per frame (1)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W    = 9;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps, raising bit_done
//   on the last cycle of each bit period. A synchronous clear holds the count
//   at zero so the first period after a clear is a full one.
//
// Ports
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   clear    in   synchronous clear, holds the counter at 0
//   bit_done out  one-cycle pulse on the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == LAST) && !clear;

endmodule : uart_baud_cnt

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   9N1 UART transmitter: start bit, 9 data bits LSB first, stop bit.
//   A frame is accepted on any edge where ready=1 and send=1; data is latched
//   at that edge and later changes are ignored. tx and ready are registered.
//
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   (XOR of the 9 data bits) between data[8] and the stop bit.
//
// Ports
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   send   in   level request to transmit data
//   data   in   [DATA_W-1:0] word to transmit, sampled at acceptance
//   tx     out  serial line, idles high
//   ready  out  high while idle and able to accept a frame
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              ready
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // The timer is held in reset while idle, so START always gets a full
    // bit period beginning on the cycle after acceptance.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .bit_done(bit_done)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (send)     state_d = START;
            START: if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done && bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            STOP:  if (bit_done) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Shift register, bit counter and parity: loaded at acceptance,
    // advanced at the end of each data bit period.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q == IDLE && send) begin
            shift_d   = data;
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^data;
`endif
        end else if (state_q == DATA && bit_done) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    // Output logic: computed from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == IDLE);
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx. Expected line values come from the frame
//   definition (start, data LSB first, optional even parity, stop), checked
//   bit period by bit period, along with ready and the idle gaps.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int N = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 12;
`else
    localparam int FRAME_BITS = 11;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * N;

    logic       clock;
    logic       reset;
    logic       send;
    logic [8:0] data;
    logic       tx;
    logic       ready;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .CLKS_PER_BIT(N),
        .DATA_W      (9)
    ) dut (
        .clock(clock),
        .reset(reset),
        .send (send),
        .data (data),
        .tx   (tx),
        .ready(ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // Line value of bit cell b (0 = start) in a frame carrying d.
    function automatic logic expected_bit(input logic [8:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 9) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 10) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({tx, ready} !== 2'b11) begin
            errors++;
            $display("FAIL %s: tx=%b ready=%b, expected tx=1 ready=1", name, tx, ready);
        end
    endtask

    // Follows one frame whose accepting edge is the next clock edge.
    // release_at: cycle after which send drops (-1 keeps it).
    // change_at : cycle after which data becomes new_data (-1 never).
    // stop_bit  : check only cells below this index (-1 whole frame).
    task automatic expect_frame(input logic [8:0] d, input int release_at,
                                input int change_at, input logic [8:0] new_data,
                                input int stop_bit, input string name);
        logic [N-1:0] tx_v;
        logic [N-1:0] rdy_v;
        logic [N-1:0] exp_v;
        int last;
        last = (stop_bit < 0) ? FRAME_BITS : stop_bit;
        for (int b = 0; b < last; b++) begin
            for (int c = 0; c < N; c++) begin
                step();
                if (b * N + c == release_at) send = 1'b0;
                if (b * N + c == change_at)  data = new_data;
                tx_v[c]  = tx;
                rdy_v[c] = ready;
            end
            exp_v = {N{expected_bit(d, b)}};
            checks++;
            if (tx_v !== exp_v) begin
                errors++;
                $display("FAIL %s cell%0d tx: got %b expected %b (data=%h)",
                         name, b, tx_v, exp_v, d);
            end
            checks++;
            if (rdy_v !== '0) begin
                errors++;
                $display("FAIL %s cell%0d ready: got %b expected all 0", name, b, rdy_v);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        send  = 1'b0;
        data  = '0;
        repeat (3) step();
        reset = 1'b0;
        check_idle("reset_state");
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle($sformatf("idle_after_reset%0d", i));
        end
    endtask

    task automatic test_single_frame();
        data = 9'b0_1101_0101;
        send = 1'b1;
        expect_frame(9'b0_1101_0101, 0, -1, '0, -1, "single");
        step();
        check_idle("single_end_ready");
        step();
        check_idle("single_stays_idle");
    endtask

    task automatic test_back_to_back();
        int frames;
        int bad;
        frames = (5000 + FRAME_CYCLES) / (FRAME_CYCLES + 1);
        data = 9'b0_1101_0101;
        send = 1'b1;
        for (int f = 0; f < frames; f++) begin
            expect_frame(9'b0_1101_0101, (f == frames - 1) ? 0 : -1, -1, '0, -1,
                         $sformatf("b2b%0d", f));
            step();
            check_idle($sformatf("b2b_gap%0d", f));
        end
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if ({tx, ready} !== 2'b11) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_release_idle: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_data_change();
        data = 9'h0A5;
        send = 1'b1;
        expect_frame(9'h0A5, 0, 5 * N + 3, 9'h1FF, -1, "chg_inflight");
        step();
        check_idle("chg_gap");
        send = 1'b1;
        expect_frame(9'h1FF, 0, -1, '0, -1, "chg_next");
        step();
        check_idle("chg_end");
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] d;
        d    = 9'($urandom);
        data = d;
        send = 1'b1;
        expect_frame(d, 0, -1, '0, 5, "rst_partial");
        repeat (6) step();
        reset = 1'b1;
        send  = 1'b1;
        step();
        reset = 1'b0;
        check_idle("rst_abort");
        expect_frame(d, 0, -1, '0, -1, "rst_fresh");
        step();
        check_idle("rst_fresh_end");
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic [8:0] nd;
        int gap;
        for (int i = 0; i < 6; i++) begin
            d   = 9'($urandom);
            nd  = 9'($urandom);
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                step();
                check_idle($sformatf("rnd%0d_gap", i));
            end
            data = d;
            send = 1'b1;
            expect_frame(d, $urandom_range(0, FRAME_CYCLES - 2),
                         $urandom_range(0, FRAME_CYCLES - 2), nd, -1,
                         $sformatf("rnd%0d", i));
            step();
            check_idle($sformatf("rnd%0d_end", i));
        end
    endtask

    initial begin
        reset = 1'b1;
        send  = 1'b0;
        data  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx
